// File: rtl/apb_pwm_pkg.sv
// Shared definitions for the APB PWM peripheral: master FSM state encoding,
// register selectors and the write-order helper used by masters and benches.
package apb_pwm_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;

    // Enabling writes CTRL last so the PWM never runs on stale period/duty;
    // disabling writes CTRL first so it stops before the values change.
    function automatic logic [1:0] reg_for_step(input logic [1:0] step, input logic enable);
        logic [1:0] sel;
        sel = REG_CTRL;
        if (enable) begin
            case (step)
                2'd0:    sel = REG_PERIOD;
                2'd1:    sel = REG_DUTY;
                default: sel = REG_CTRL;
            endcase
        end else begin
            case (step)
                2'd0:    sel = REG_CTRL;
                2'd1:    sel = REG_PERIOD;
                default: sel = REG_DUTY;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS-phase wait cycles; expired flags the last allowed cycle.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/apb_pwm_cfg_master.sv
// APB master turning one host configuration request into three back-to-back
// PWM register writes, with wait-state handling and per-transfer timeout.
module apb_pwm_cfg_master
    import apb_pwm_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16,
    parameter int ADDR_CTRL   = 0,
    parameter int ADDR_PERIOD = 1,
    parameter int ADDR_DUTY   = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_period,
    input  logic [DATA_W-1:0] cfg_duty,
    input  logic              cfg_enable,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    output logic              done,
    output logic              err
);

    logic [1:0]        state;
    logic [1:0]        idx;
    logic [DATA_W-1:0] period_q;
    logic [DATA_W-1:0] duty_q;
    logic              enable_q;
    logic              timer_clr;
    logic              timer_inc;
    logic              timer_expired;
    logic [1:0]        first_sel;
    logic [1:0]        next_sel;

    function automatic logic [ADDR_W-1:0] addr_for(input logic [1:0] sel);
        logic [ADDR_W-1:0] a;
        case (sel)
            REG_PERIOD: a = ADDR_W'(ADDR_PERIOD);
            REG_DUTY:   a = ADDR_W'(ADDR_DUTY);
            default:    a = ADDR_W'(ADDR_CTRL);
        endcase
        return a;
    endfunction

    function automatic logic [DATA_W-1:0] data_for(input logic [1:0] sel,
                                                   input logic [DATA_W-1:0] period,
                                                   input logic [DATA_W-1:0] duty,
                                                   input logic enable);
        logic [DATA_W-1:0] d;
        case (sel)
            REG_PERIOD: d = period;
            REG_DUTY:   d = duty;
            default:    d = {{(DATA_W-1){1'b0}}, enable};
        endcase
        return d;
    endfunction

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    assign timer_clr = (state == ST_SETUP);
    assign timer_inc = (state == ST_ACCESS) && !PREADY;
    assign first_sel = reg_for_step(2'd0, cfg_enable);
    assign next_sel  = reg_for_step(idx + 2'd1, enable_q);

    // Outputs are registered from the next-state decision so the bus sees
    // clean values for the whole cycle; PREADY only feeds that decode.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            period_q  <= '0;
            duty_q    <= '0;
            enable_q  <= 1'b0;
            cfg_ready <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        period_q  <= cfg_period;
                        duty_q    <= cfg_duty;
                        enable_q  <= cfg_enable;
                        idx       <= 2'd0;
                        state     <= ST_SETUP;
                        cfg_ready <= 1'b0;
                        PSEL      <= 1'b1;
                        PWRITE    <= 1'b1;
                        PENABLE   <= 1'b0;
                        PADDR     <= addr_for(first_sel);
                        PWDATA    <= data_for(first_sel, cfg_period, cfg_duty, cfg_enable);
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (PREADY && idx != 2'd2) begin
                        idx     <= idx + 2'd1;
                        state   <= ST_SETUP;
                        PENABLE <= 1'b0;
                        PADDR   <= addr_for(next_sel);
                        PWDATA  <= data_for(next_sel, period_q, duty_q, enable_q);
                    end else if (PREADY || timer_expired) begin
                        state     <= ST_IDLE;
                        idx       <= 2'd0;
                        cfg_ready <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b0;
                        PADDR     <= '0;
                        PWDATA    <= '0;
                        done      <= 1'b1;
                        err       <= !PREADY;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    idx       <= 2'd0;
                    cfg_ready <= 1'b1;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    PWRITE    <= 1'b0;
                    PADDR     <= '0;
                    PWDATA    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_pwm_cfg_master.sv
// Scoreboard bench for apb_pwm_cfg_master: expected writes and done/err
// outcomes are queued by the stimulus and checked by an independent monitor.
module tb_apb_pwm_cfg_master;

    localparam logic [31:0] NO_STALL = 32'hFFFF_FFFF;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_duty = '0;
    logic        cfg_ready;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic        exp_err_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] stall_addr = NO_STALL;
    int          stall_cycles = 0;
    int          acc_idx = 0;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    apb_pwm_cfg_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(16),
        .ADDR_CTRL(0), .ADDR_PERIOD(1), .ADDR_DUTY(2)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_enable (cfg_enable),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .done       (done),
        .err        (err)
    );

    always #5 PCLK = ~PCLK;

    // acc_idx is k during the k-th ACCESS cycle; the slave stalls the
    // selected address for stall_cycles cycles.
    always @(posedge PCLK) begin
        #1;
        if (PSEL && PENABLE) acc_idx = acc_idx + 1;
        else acc_idx = 0;
    end

    assign PREADY = !(PSEL && PENABLE && (PADDR == stall_addr) && (acc_idx <= stall_cycles));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_xfer(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back(xfer_t'({a, d}));
    endtask

    always @(negedge PCLK) begin
        xfer_t e;
        if (PRESET) begin
            prev_acc = 1'b0;
        end else begin
            if (PSEL && PENABLE && PREADY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", PADDR, NO_STALL);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_addr", PADDR, e.addr);
                    check("xfer_data", PWDATA, e.data);
                    check("xfer_pwrite", {31'd0, PWRITE}, 32'd1);
                end
            end
            if (PSEL && PENABLE && prev_acc) begin
                check("access_addr_stable", PADDR, prev_addr);
                check("access_data_stable", PWDATA, prev_data);
            end
            prev_acc  = PSEL && PENABLE;
            prev_addr = PADDR;
            prev_data = PWDATA;
            if (done) begin
                if (exp_err_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    check("done_err", {31'd0, err}, {31'd0, exp_err_q.pop_front()});
                    check("done_psel_low", {31'd0, PSEL}, 32'd0);
                end
            end else if (err) begin
                check("err_without_done", {31'd0, err}, 32'd0);
            end
        end
    end

    task automatic run_seq(input logic [31:0] p, input logic [31:0] d, input logic en,
                           input int exp_cycle, input int exp_psel, input bit hold_valid);
        int cyc;
        int psel_cnt;
        bit seen;
        @(negedge PCLK);
        check("ready_idle", {31'd0, cfg_ready}, 32'd1);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_duty   = d;
        cfg_enable = en;
        @(negedge PCLK);
        cyc = 1;
        check("ready_busy", {31'd0, cfg_ready}, 32'd0);
        if (hold_valid) begin
            cfg_period = 32'h0000_dead;
            cfg_duty   = 32'h0000_beef;
            cfg_enable = ~en;
        end else begin
            cfg_valid = 1'b0;
        end
        psel_cnt = 0;
        seen = 1'b0;
        while (cyc <= 100 && !seen) begin
            if (PSEL) psel_cnt = psel_cnt + 1;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(negedge PCLK);
                cyc = cyc + 1;
            end
        end
        cfg_valid = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("done_cycle", cyc, exp_cycle);
        check("psel_cycles", psel_cnt, exp_psel);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},    {31'd0, PSEL},      32'd0);
        check({tag, "_penable"}, {31'd0, PENABLE},   32'd0);
        check({tag, "_pwrite"},  {31'd0, PWRITE},    32'd0);
        check({tag, "_paddr"},   PADDR,              32'd0);
        check({tag, "_pwdata"},  PWDATA,             32'd0);
        check({tag, "_done"},    {31'd0, done},      32'd0);
        check({tag, "_err"},     {31'd0, err},       32'd0);
        check({tag, "_ready"},   {31'd0, cfg_ready}, 32'd1);
    endtask

    initial begin
        #1 PRESET = 1'b1;
        #1 check_reset_outputs("rst0");
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        // enable=1: PERIOD, DUTY, CTRL
        push_xfer(32'd1, 32'd120);
        push_xfer(32'd2, 32'd5);
        push_xfer(32'd0, 32'd1);
        exp_err_q.push_back(1'b0);
        run_seq(32'd120, 32'd5, 1'b1, 7, 6, 1'b0);

        // enable=0: CTRL, PERIOD, DUTY
        push_xfer(32'd0, 32'd0);
        push_xfer(32'd1, 32'd200);
        push_xfer(32'd2, 32'd50);
        exp_err_q.push_back(1'b0);
        run_seq(32'd200, 32'd50, 1'b0, 7, 6, 1'b0);

        // three wait states on the DUTY write
        stall_addr = 32'd2;
        stall_cycles = 3;
        push_xfer(32'd1, 32'd120);
        push_xfer(32'd2, 32'd5);
        push_xfer(32'd0, 32'd1);
        exp_err_q.push_back(1'b0);
        run_seq(32'd120, 32'd5, 1'b1, 10, 9, 1'b0);

        // DUTY write never completes: 16-cycle ACCESS then abort, CTRL dropped
        stall_cycles = 1000;
        push_xfer(32'd1, 32'd120);
        exp_err_q.push_back(1'b1);
        run_seq(32'd120, 32'd5, 1'b1, 20, 19, 1'b1);
        stall_addr = NO_STALL;
        stall_cycles = 0;

        // reset in the middle of the PERIOD write's ACCESS phase
        stall_addr = 32'd1;
        stall_cycles = 1000;
        @(negedge PCLK);
        cfg_valid  = 1'b1;
        cfg_period = 32'd77;
        cfg_duty   = 32'd9;
        cfg_enable = 1'b1;
        @(negedge PCLK);
        cfg_valid = 1'b0;
        @(negedge PCLK);
        check("mid_access_penable", {31'd0, PENABLE}, 32'd1);
        check("mid_access_paddr", PADDR, 32'd1);
        #1 PRESET = 1'b1;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        stall_addr = NO_STALL;
        stall_cycles = 0;

        push_xfer(32'd1, 32'd10);
        push_xfer(32'd2, 32'd3);
        push_xfer(32'd0, 32'd1);
        exp_err_q.push_back(1'b0);
        run_seq(32'd10, 32'd3, 1'b1, 7, 6, 1'b0);

        repeat (3) @(negedge PCLK);
        check("xfer_queue_empty", exp_q.size(), 32'd0);
        check("done_queue_empty", exp_err_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
